// File: rtl/serial_subtractor_pkg.sv
// Shared types and helpers for the bit-serial subtractor.
// Holds the controller state encoding and the step-counter width function.
package serial_subtractor_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Never narrower than one bit, so WIDTH=2 still gets a real counter.
    function automatic int cnt_width(input int w);
        return (w <= 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// One-bit full subtractor: computes a - b - bin.
// diff is the result bit; bout is the borrow passed to the next bit.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic diff,
    output logic bout
);

    assign diff = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial LSB-first subtractor: diff = a - b over WIDTH cycles.
// One full-subtractor cell plus operand/result shift registers.
//
// state | meaning
// IDLE  | waiting for start; a/b captured on the accepting edge
// RUN   | one bit per edge through the subtractor cell, WIDTH edges
// DONE  | result registered; done high for exactly one cycle
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
);

    localparam int CW = cnt_width(WIDTH);

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-2:0] res;
    logic [WIDTH-1:0] shifted;
    logic             bin;
    logic [CW-1:0]    cnt;
    logic             last;
    logic             d;
    logic             bout;

    full_subtractor u_fs (
        .a    (op_a[0]),
        .b    (op_b[0]),
        .bin  (bin),
        .diff (d),
        .bout (bout)
    );

    // Result register shifted with this step's bit; complete on the last step.
    assign shifted = {d, res};
    assign last    = (cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (last)  state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == RUN);
        done = (state == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_a   <= '0;
            op_b   <= '0;
            res    <= '0;
            bin    <= 1'b0;
            cnt    <= '0;
            diff   <= '0;
            borrow <= 1'b0;
        end else begin
            if (state == IDLE && start) begin
                op_a <= a;
                op_b <= b;
                res  <= '0;
                bin  <= 1'b0;
                cnt  <= '0;
            end else if (state == RUN) begin
                op_a <= {1'b0, op_a[WIDTH-1:1]};
                op_b <= {1'b0, op_b[WIDTH-1:1]};
                res  <= shifted[WIDTH-1:1];
                bin  <= bout;
                cnt  <= cnt + CW'(1);
                if (last) begin
                    diff   <= shifted;
                    borrow <= bout;
                end
            end
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor: full-subtractor truth table, directed
// vectors, start/reset corner sequences and a long random back-to-back run.
module tb_serial_subtractor;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         borrow;

    logic fs_a = 1'b0, fs_b = 1'b0, fs_bin = 1'b0;
    logic fs_diff, fs_bout;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .diff   (diff),
        .borrow (borrow)
    );

    full_subtractor u_fs (
        .a    (fs_a),
        .b    (fs_b),
        .bin  (fs_bin),
        .diff (fs_diff),
        .bout (fs_bout)
    );

    typedef struct {
        logic a, b, bin;
        logic diff, bout;
    } fs_vec_t;

    typedef struct {
        logic [W-1:0] a, b;
        logic [W-1:0] diff;
        logic         borrow;
    } op_vec_t;

    fs_vec_t fs_tab[8];
    op_vec_t op_tab[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Waits for done, counting busy cycles; bounded so a dead DUT cannot hang the run.
    task automatic wait_done(output int nbusy, output bit seen);
        nbusy = 0;
        seen  = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
            else if (busy) nbusy++;
        end
        if (!seen) chk("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic launch(input logic [W-1:0] va, input logic [W-1:0] vb);
        @(negedge clk);
        a = va;
        b = vb;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic run_op(input op_vec_t v, input string name);
        int nb;
        bit seen;
        launch(v.a, v.b);
        wait_done(nb, seen);
        chk({name, "_busy_cycles"}, nb, W);
        chk({name, "_diff"}, diff, v.diff);
        chk({name, "_borrow"}, borrow, v.borrow);
        @(negedge clk);
        chk({name, "_done_one_cycle"}, done, 1'b0);
    endtask

    initial begin
        int nb;
        bit seen;
        int ndone;
        logic [W-1:0] ra, rb, held_diff;
        logic [W:0]   ref_full;
        logic         held_borrow;
        int cyc, last_cyc;

        fs_tab[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        fs_tab[1] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        fs_tab[2] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        fs_tab[3] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        fs_tab[4] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        fs_tab[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        fs_tab[6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        fs_tab[7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

        op_tab[0] = '{8'h5A, 8'h3C, 8'h1E, 1'b0};
        op_tab[1] = '{8'h00, 8'h01, 8'hFF, 1'b1};
        op_tab[2] = '{8'h80, 8'h80, 8'h00, 1'b0};
        op_tab[3] = '{8'hFF, 8'h00, 8'hFF, 1'b0};
        op_tab[4] = '{8'h00, 8'hFF, 8'h01, 1'b1};
        op_tab[5] = '{8'h01, 8'h00, 8'h01, 1'b0};

        for (int i = 0; i < 8; i++) begin
            fs_a = fs_tab[i].a;
            fs_b = fs_tab[i].b;
            fs_bin = fs_tab[i].bin;
            #1;
            chk($sformatf("fs_diff_%0d", i), fs_diff, fs_tab[i].diff);
            chk($sformatf("fs_bout_%0d", i), fs_bout, fs_tab[i].bout);
        end

        #3;
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_diff", diff, '0);
        chk("rst_borrow", borrow, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++) run_op(op_tab[i], $sformatf("vec%0d", i));

        // Second start while busy must be ignored, with no extra done pulse.
        launch(8'h5A, 8'h3C);
        @(negedge clk);
        @(negedge clk);
        a = 8'hFF;
        b = 8'h00;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(nb, seen);
        chk("ignore_diff", diff, 8'h1E);
        chk("ignore_borrow", borrow, 1'b0);
        ndone = 0;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        chk("ignore_no_extra_done", ndone, 0);

        // Asynchronous reset mid-operation: outputs clear before the next edge.
        launch(8'h00, 8'h01);
        repeat (3) @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_busy", busy, 1'b0);
        chk("abort_done", done, 1'b0);
        chk("abort_diff", diff, '0);
        chk("abort_borrow", borrow, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        chk("abort_no_done", ndone, 0);
        run_op('{8'h10, 8'h01, 8'h0F, 1'b0}, "post_abort");

        // Back-to-back with start held high; operands change only when done is seen,
        // so each accepted operand pair is the one most recently driven.
        held_diff = 8'h0F;
        held_borrow = 1'b0;
        cyc = 0;
        last_cyc = 0;
        @(negedge clk);
        ra = W'($urandom);
        rb = W'($urandom);
        a = ra;
        b = rb;
        start = 1'b1;
        for (int op = 0; op < 1000; op++) begin
            seen = 1'b0;
            for (int k = 0; k < 30 && !seen; k++) begin
                @(negedge clk);
                cyc++;
                if (done) begin
                    seen = 1'b1;
                end else if (diff !== held_diff || borrow !== held_borrow) begin
                    chk("rand_hold_diff", diff, held_diff);
                    chk("rand_hold_borrow", borrow, held_borrow);
                end
            end
            if (!seen) begin
                chk("rand_done_timeout", 32'd0, 32'd1);
                break;
            end
            ref_full = {1'b0, ra} - {1'b0, rb};
            chk("rand_diff", diff, ref_full[W-1:0]);
            chk("rand_borrow", borrow, ref_full[W]);
            if (op > 0) chk("rand_period", cyc - last_cyc, W + 2);
            last_cyc = cyc;
            held_diff = ref_full[W-1:0];
            held_borrow = ref_full[W];
            ra = W'($urandom);
            rb = W'($urandom);
            a = ra;
            b = rb;
            if (op == 999) start = 1'b0;
        end

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial, LSB-first subtractor computing DIFF = A - B over WIDTH clock cycles.
- Processes one bit per cycle through a single full-subtractor cell, which is the inverse-direction counterpart of the full-adder cell.
- Sits in the arithmetic test-circuit area.
- Trades area for latency: one cell plus shift registers instead of a WIDTH-bit ripple chain.
- Uses a start/busy/done handshake toward the controlling logic.

Parameters:
- WIDTH, 8, operand and result width in bits; legal range 2..32.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request an operation; sampled only in IDLE.
- a  input  WIDTH  minuend; captured on the edge that accepts start.
- b  input  WIDTH  subtrahend; captured on the edge that accepts start.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse when the result is valid.
- diff  output  WIDTH  registered result (a - b) mod 2^WIDTH.
- borrow  output  1  registered final borrow-out; 1 when a < b (unsigned).

Behaviour:
- Clock and reset:
  - One clock domain.
  - Reset is asynchronous and active-low.
  - While rst_n=0: state=IDLE, busy=0, done=0, diff=0, borrow=0, internal shift registers, counter and borrow flop all 0.
- States: IDLE, RUN, DONE. busy = (state==RUN); done = (state==DONE). Both are decoded from registered state, so they are glitch-free.
- IDLE:
  - start=1 at edge t0: load opA<=a, opB<=b, bin<=0, cnt<=0, go to RUN.
  - start=0: stay in IDLE.
- RUN: on each edge, one bit step.
  - d = opA[0] ^ opB[0] ^ bin
  - bout = (~opA[0] & opB[0]) | (~(opA[0] ^ opB[0]) & bin)
  - opA and opB shift right by 1.
  - Internal result shift register shifts right with d inserted at the MSB.
  - bin <= bout; cnt <= cnt+1.
- RUN exit:
  - On the edge where cnt==WIDTH-1 (the WIDTH-th RUN edge, t0+WIDTH), go to DONE.
  - On that same edge, load diff with the final shifted value (including this bit's d) and load borrow with this bit's bout.
- DONE: lasts exactly one cycle (done high between edges t0+WIDTH and t0+WIDTH+1), then IDLE.
- Latency: result valid and done=1 WIDTH edges after the accepting edge. Minimum start-to-start period is WIDTH+2 cycles.
- Output holding:
  - diff and borrow change only on entry to DONE.
  - They hold the last result through IDLE and the next RUN; partial results are never visible.
- start in RUN or DONE: ignored; no queuing. a and b are don't-care outside the accepting edge.
- start held high continuously: a new operation is accepted on the first IDLE edge after DONE.
- Reset mid-operation: immediate abort; outputs cleared as above; no done pulse.
- Counter width: $clog2(WIDTH), wrap not reachable.
- Arithmetic is unsigned and modulo 2^WIDTH; no overflow flag.

Decomposition:
- Shared package: state enum (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and the counter-width constant function.
- One natural sub-module: full_subtractor, combinational.
  - Ports: a, b, bin -> diff, bout.
  - Instantiated once in the datapath and unit-tested standalone against all 8 input combinations.

Test Plan:
- Reset: rst_n=0 asserted asynchronously mid-cycle -> diff=0, borrow=0, busy=0, done=0 immediately, before the next clock edge.
- Basic (WIDTH=8): a=0x5A, b=0x3C, start pulse at t0 -> busy high for 8 cycles; done at t0+8; diff=0x1E, borrow=0.
- Wrap/borrow: a=0x00, b=0x01 -> diff=0xFF, borrow=1. Also a=0x80, b=0x80 -> diff=0x00, borrow=0.
- Start while busy: second start with a=0xFF, b=0x00 at t0+3 -> ignored; first result 0x1E delivered; no extra done.
- Reset mid-op: rst_n pulsed low at t0+4 -> state IDLE, outputs 0, no done. Subsequent start with a=0x10, b=0x01 -> diff=0x0F, borrow=0.
- Back-to-back with start held high, random a/b over 1000 operations:
  - done exactly every 10 cycles.
  - Each diff/borrow matches a reference model of {borrow,diff} = {1'b0,a} - {1'b0,b}.
  - Outputs stable between done pulses.
